// File: rtl/seven_segment_controller_pkg.sv
// Shared definitions for the seven-segment display device: hex-to-segment
// table, digit-register layout, pin polarity constants and FSM states.
package seven_segment_controller_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned VAL_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PIN_W      = 8;
  localparam int unsigned REG_W      = 6;

  // Digit register field offsets
  localparam int unsigned VALUE_LSB = 0;
  localparam int unsigned DP_BIT    = 4;
  localparam int unsigned EN_BIT    = 5;

  // Active-low "all off" pin levels
  localparam logic [PIN_W-1:0]      SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'hF;

  // Active-high g..a patterns for hex digits 0..F
  localparam logic [SEG_W-1:0] HEX_SEG [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Digit register payload; bit layout matches wr_data (EN=5, DP=4, VALUE=3:0)
  typedef struct packed {
    logic             en;
    logic             dp;
    logic [VAL_W-1:0] value;
  } digit_reg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Active-low one-hot digit select for a digit index
  function automatic logic [NUM_DIGITS-1:0] digit_sel_n(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex to 7-segment decoder (active-high, bit 6 = g .. bit 0 = a).
//   i_hex    : 4-bit hex value
//   o_seg_c  : 7-bit active-high segment pattern
module seven_segment_decoder
  import seven_segment_controller_pkg::*;
(
  input  logic [VAL_W-1:0] i_hex,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_SEG[i_hex];

endmodule

// File: rtl/seven_segment_controller.sv
// Four-digit multiplexed seven-segment display driver with per-digit
// registers and a blanking gap at the start of every digit slot.
//   clk, rst      : system clock, synchronous active-high reset
//   wr_en/addr/data: digit register write port ([3:0] value, [4] dp, [5] enable)
//   segment_pins  : active-low segments, [6:0] = g..a, [7] = dp (registered)
//   digit_pins    : active-low digit selects, bit i = digit i (registered)
module seven_segment_controller
  import seven_segment_controller_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 50000,
  parameter int unsigned BLANK_TICKS   = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [REG_W-1:0]      wr_data,
  output logic [PIN_W-1:0]      segment_pins,
  output logic [NUM_DIGITS-1:0] digit_pins
);

  localparam int unsigned CNT_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(REFRESH_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_TICKS - 1);

  digit_reg_t            r_digits [NUM_DIGITS];
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  state_e                r_state;
  state_e                w_state_nxt;
  logic [PIN_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic [PIN_W-1:0]      w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_dig_nxt;
  logic                  w_wrap;
  digit_reg_t            w_cur;
  logic [SEG_W-1:0]      w_pattern;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign w_cur  = r_digits[r_idx];

  seven_segment_decoder u_decoder (
    .i_hex   (w_cur.value),
    .o_seg_c (w_pattern)
  );

  // Digit registers; writes accepted in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        r_digits[i] <= '0;
      end
    end else if (wr_en) begin
      r_digits[wr_addr] <= digit_reg_t'(wr_data);
    end
  end

  // Slot counter, digit index and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_nxt;
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next state and next pin values from current state, index and register
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = SEG_OFF;
    w_dig_nxt   = DIG_OFF;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_BLANK_END) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_wrap) w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_BLANK;
    endcase
    // Disabled digits keep their slot but stay dark
    if (r_state == ST_SHOW && w_cur.en) begin
      w_seg_nxt = ~{w_cur.dp, w_pattern};
      w_dig_nxt = digit_sel_n(r_idx);
    end
  end

  // Registered pins; reset forces all-off on the reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_dig <= DIG_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign segment_pins = r_seg;
  assign digit_pins   = r_dig;

endmodule

// File: tb/tb_seven_segment_controller.sv
// Directed bench for seven_segment_controller with a small slot-timing model.
module tb_seven_segment_controller;

  localparam int RT = 8;
  localparam int BT = 2;
  localparam logic [6:0] DEC [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic [7:0] segment_pins;
  logic [3:0] digit_pins;

  int checks = 0;
  int failures = 0;
  int k = 0;
  logic [5:0] m_regs [4];

  seven_segment_controller #(.REFRESH_TICKS(RT), .BLANK_TICKS(BT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .segment_pins (segment_pins),
    .digit_pins   (digit_pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Drive one edge's inputs, then check pins against the slot model
  task automatic cyc(input logic we, input logic [1:0] a, input logic [5:0] d, input logic r);
    int p;
    int s;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    rst = r; wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    @(negedge clk);
    e_seg = 8'hFF;
    e_dig = 4'hF;
    if (r) begin
      k = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
    end else begin
      k++;
      p = (k - 1) % RT;
      s = ((k - 1) / RT) % 4;
      if (p >= BT && m_regs[s][5]) begin
        e_seg = ~{m_regs[s][4], DEC[m_regs[s][3:0]]};
        e_dig = 4'hF;
        e_dig[s] = 1'b0;
      end
    end
    check("seg", 32'(segment_pins), 32'(e_seg));
    check("dig", 32'(digit_pins), 32'(e_dig));
    check("onehot", 32'($countones(~digit_pins) <= 1), 32'd1);
    if (!r && we) m_regs[a] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 6'd0, 1'b0);
  endtask

  // Advance until the last edge put the scan at (slot, pos)
  task automatic wait_pos(input int slot, input int pos);
    int n = 0;
    while (!(k > 0 && ((k - 1) / RT) % 4 == slot && (k - 1) % RT == pos) && n < 64) begin
      idle(1);
      n++;
    end
    check("wait_pos", 32'(n < 64), 32'd1);
  endtask

  initial begin
    int run;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    @(negedge clk);

    // Reset held three cycles, then dark display with no writes
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 6'd0, 1'b1);
    check("rst_seg", 32'(segment_pins), 32'hFF);
    check("rst_dig", 32'(digit_pins), 32'hF);
    idle(64);

    // Single digit 0, value 0: six lit cycles per 32-cycle period
    cyc(1'b1, 2'd0, 6'b100000, 1'b0);
    run = 0;
    for (int i = 0; i < 32; i++) begin
      idle(1);
      if (digit_pins == 4'b1110 && segment_pins == 8'hC0) run++;
    end
    check("single_run", 32'(run), 32'd6);

    // All digits: 1, A, b with dp, F
    cyc(1'b1, 2'd0, 6'h21, 1'b0);
    cyc(1'b1, 2'd1, 6'h2A, 1'b0);
    cyc(1'b1, 2'd2, 6'h3B, 1'b0);
    cyc(1'b1, 2'd3, 6'h2F, 1'b0);
    idle(64);

    // Live update of digit 1 during SHOW: 88 -> 92 one edge after the write
    wait_pos(1, 4);
    check("live_pre", 32'(segment_pins), 32'h88);
    cyc(1'b1, 2'd1, 6'h25, 1'b0);
    check("live_wr_edge", 32'(segment_pins), 32'h88);
    idle(1);
    check("live_seg", 32'(segment_pins), 32'h92);
    check("live_dig", 32'(digit_pins), 32'hD);
    idle(40);

    // Disable digit 3 mid-run
    cyc(1'b1, 2'd3, 6'h0F, 1'b0);
    idle(64);

    // Reset during digit 2 SHOW
    wait_pos(2, 4);
    check("pre_rst_dig", 32'(digit_pins), 32'hB);
    cyc(1'b0, 2'd0, 6'd0, 1'b1);
    check("midrst_seg", 32'(segment_pins), 32'hFF);
    check("midrst_dig", 32'(digit_pins), 32'hF);
    cyc(1'b1, 2'd2, 6'h3B, 1'b1);
    cyc(1'b0, 2'd0, 6'd0, 1'b1);

    // Restart at digit 0 with blank; digit 2 stays dark until rewritten
    cyc(1'b1, 2'd0, 6'h23, 1'b0);
    cyc(1'b1, 2'd1, 6'h27, 1'b0);
    check("restart_blank_seg", 32'(segment_pins), 32'hFF);
    check("restart_blank_dig", 32'(digit_pins), 32'hF);
    cyc(1'b1, 2'd3, 6'h28, 1'b0);
    check("restart_d0_dig", 32'(digit_pins), 32'hE);
    check("restart_d0_seg", 32'(segment_pins), 32'hB0);
    idle(64);
    cyc(1'b1, 2'd2, 6'h1E, 1'b0);
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
